// File: rtl/bus_matrix_pkg.sv
// Shared types, widths and default sizing for the bus matrix.
package bus_matrix_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 2;
    localparam int REG_DATA_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] TCM_ADDR   = 32'h8000_0000;
    localparam logic [ADDR_WIDTH-1:0] TCM_SIZE   = 32'h0001_0000;
    localparam logic [ADDR_WIDTH-1:0] CLINT_ADDR = 32'h0200_0000;
    localparam logic [ADDR_WIDTH-1:0] CLINT_SIZE = 32'h0001_0000;

    localparam int DEF_M_NUM   = 3;
    localparam int DEF_S_NUM   = 3;
    localparam int DEF_TIMEOUT = 64;

    // Per-master transaction state.
    typedef enum logic [2:0] {
        M_IDLE,
        M_DECERR,
        M_ARB,
        M_SLV,
        M_RESP
    } m_state_e;

    // Width of the per-slave timeout counter (counts 0 .. TIMEOUT-1).
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    // Width needed to index n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_matrix_if.sv
// Master-side and slave-side signal bundle of the bus matrix.
interface bus_matrix_if
    import bus_matrix_pkg::*;
#(
    parameter int M_NUM = DEF_M_NUM,
    parameter int S_NUM = DEF_S_NUM
) ();

    logic [M_NUM-1:0]                     m_req;
    logic [M_NUM-1:0]                     m_we;
    logic [M_NUM-1:0][ADDR_WIDTH-1:0]     m_addr;
    logic [M_NUM-1:0][SIZE_WIDTH-1:0]     m_size;
    logic [M_NUM-1:0][REG_DATA_WIDTH-1:0] m_wdata;
    logic [M_NUM-1:0]                     m_busy;
    logic [M_NUM-1:0]                     m_ack;
    logic [M_NUM-1:0]                     m_err;
    logic [M_NUM-1:0][BUS_DATA_WIDTH-1:0] m_rdata;

    logic [S_NUM-1:0]                     s_req;
    logic [S_NUM-1:0]                     s_we;
    logic [S_NUM-1:0][ADDR_WIDTH-1:0]     s_addr;
    logic [S_NUM-1:0][SIZE_WIDTH-1:0]     s_size;
    logic [S_NUM-1:0][REG_DATA_WIDTH-1:0] s_wdata;
    logic [S_NUM-1:0]                     s_ack;
    logic [S_NUM-1:0][BUS_DATA_WIDTH-1:0] s_rdata;

    // Requesting devices (fetch / store buffer ports).
    modport master (
        output m_req, m_we, m_addr, m_size, m_wdata,
        input  m_busy, m_ack, m_err, m_rdata
    );

    // Target devices (TCM, CLINT, ...).
    modport slave (
        input  s_req, s_we, s_addr, s_size, s_wdata,
        output s_ack, s_rdata
    );

    // The matrix itself sits between both sides.
    modport matrix (
        input  m_req, m_we, m_addr, m_size, m_wdata,
        output m_busy, m_ack, m_err, m_rdata,
        output s_req, s_we, s_addr, s_size, s_wdata,
        input  s_ack, s_rdata
    );

endinterface

// File: rtl/bus_matrix_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, pointer moves past the winner.
module bus_matrix_rr_arbiter
    import bus_matrix_pkg::*;
#(
    parameter int M_NUM = DEF_M_NUM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [M_NUM-1:0]            req,
    output logic [M_NUM-1:0]            grant,
    output logic [idx_width(M_NUM)-1:0] ptr
);

    localparam int PW = idx_width(M_NUM);

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [M_NUM-1:0] grant_c;
    logic             found;
    int unsigned      idx;

    // Search requesters starting at the pointer, wrapping around.
    always_comb begin
        grant_c = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < M_NUM; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= M_NUM) begin
                idx = idx - M_NUM;
            end
            if (en && !found && req[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
                ptr_d        = (idx == M_NUM - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = grant_c;
    assign ptr   = ptr_q;

endmodule

// File: rtl/bus_matrix.sv
// Multi-master / multi-slave bus matrix with address decode, per-slave
// round-robin arbitration and per-slave acknowledge timeout.
module bus_matrix
    import bus_matrix_pkg::*;
#(
    parameter int M_NUM = DEF_M_NUM,
    parameter int S_NUM = DEF_S_NUM,
    parameter logic [S_NUM-1:0][ADDR_WIDTH-1:0] S_BASE = {32'h0, CLINT_ADDR, TCM_ADDR},
    parameter logic [S_NUM-1:0][ADDR_WIDTH-1:0] S_SIZE = {32'h0, CLINT_SIZE, TCM_SIZE},
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    bus_matrix_if.matrix  bus
);

    localparam int SW = idx_width(S_NUM);
    localparam int MW = idx_width(M_NUM);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    // Master-side state.
    m_state_e                             st_q [M_NUM];
    m_state_e                             st_d [M_NUM];
    logic [M_NUM-1:0][ADDR_WIDTH-1:0]     addr_q;
    logic [M_NUM-1:0]                     we_q;
    logic [M_NUM-1:0][SIZE_WIDTH-1:0]     size_q;
    logic [M_NUM-1:0][REG_DATA_WIDTH-1:0] wdata_q;
    logic [M_NUM-1:0][SW-1:0]             tgt_q;
    logic [M_NUM-1:0][BUS_DATA_WIDTH-1:0] rdata_q;
    logic [M_NUM-1:0]                     err_q;
    logic [M_NUM-1:0]                     acc;
    logic [M_NUM-1:0]                     dec_hit;
    logic [M_NUM-1:0][SW-1:0]             dec_idx;
    logic [M_NUM-1:0]                     m_granted;

    // Slave-side state.
    logic [S_NUM-1:0]                     s_busy_q;
    logic [S_NUM-1:0]                     s_req_q;
    logic [S_NUM-1:0]                     s_we_q;
    logic [S_NUM-1:0][ADDR_WIDTH-1:0]     s_addr_q;
    logic [S_NUM-1:0][SIZE_WIDTH-1:0]     s_size_q;
    logic [S_NUM-1:0][REG_DATA_WIDTH-1:0] s_wdata_q;
    logic [CW-1:0]                        cnt_q [S_NUM];
    logic [S_NUM-1:0]                     s_done;
    logic [S_NUM-1:0]                     s_tmo;
    logic [S_NUM-1:0]                     s_gnt_any;

    // Arbitration.
    logic [M_NUM-1:0]                     arb_req [S_NUM];
    logic [M_NUM-1:0]                     grant   [S_NUM];
    logic [MW-1:0]                        arb_ptr [S_NUM];

    // Granted master's command, re-based to the slave window.
    logic [ADDR_WIDTH-1:0]                sel_addr  [S_NUM];
    logic                                 sel_we    [S_NUM];
    logic [SIZE_WIDTH-1:0]                sel_size  [S_NUM];
    logic [REG_DATA_WIDTH-1:0]            sel_wdata [S_NUM];

    // Lowest-numbered enabled window containing the address wins.
    function automatic logic [SW:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic          hit;
        logic [SW-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int unsigned s = 0; s < S_NUM; s++) begin
            if (!hit && (S_SIZE[s] != '0) && (a >= S_BASE[s]) &&
                ({1'b0, a} < ({1'b0, S_BASE[s]} + {1'b0, S_SIZE[s]}))) begin
                hit = 1'b1;
                idx = SW'(s);
            end
        end
        return {hit, idx};
    endfunction

    // Decode incoming addresses and qualify acceptance (m_busy low).
    always_comb begin
        acc     = '0;
        dec_hit = '0;
        dec_idx = '0;
        for (int unsigned m = 0; m < M_NUM; m++) begin
            {dec_hit[m], dec_idx[m]} = decode(bus.m_addr[m]);
            acc[m] = bus.m_req[m] && ((st_q[m] == M_IDLE) || (st_q[m] == M_RESP));
        end
    end

    // Slave completion events: ack only counts after the s_req cycle.
    always_comb begin
        s_done = '0;
        s_tmo  = '0;
        for (int unsigned s = 0; s < S_NUM; s++) begin
            s_done[s] = s_busy_q[s] && !s_req_q[s] && bus.s_ack[s];
            s_tmo[s]  = s_busy_q[s] && !s_done[s] && (cnt_q[s] == TMO_LAST);
        end
    end

    // Per-slave request vectors for the arbiters.
    always_comb begin
        for (int unsigned s = 0; s < S_NUM; s++) begin
            arb_req[s] = '0;
            for (int unsigned m = 0; m < M_NUM; m++) begin
                arb_req[s][m] = (st_q[m] == M_ARB) && (tgt_q[m] == SW'(s));
            end
        end
    end

    for (genvar s = 0; s < S_NUM; s++) begin : g_arb
        bus_matrix_rr_arbiter #(
            .M_NUM (M_NUM)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .en    (!s_busy_q[s]),
            .req   (arb_req[s]),
            .grant (grant[s]),
            .ptr   (arb_ptr[s])
        );

        ptr_in_range: assert property (@(posedge clk) disable iff (!rst)
            (32'(arb_ptr[s]) < 32'(M_NUM)));
    end

    // Collapse per-slave grants per master and mux the winner's command.
    always_comb begin
        m_granted = '0;
        s_gnt_any = '0;
        for (int unsigned s = 0; s < S_NUM; s++) begin
            sel_addr[s]  = '0;
            sel_we[s]    = 1'b0;
            sel_size[s]  = '0;
            sel_wdata[s] = '0;
            s_gnt_any[s] = |grant[s];
            for (int unsigned m = 0; m < M_NUM; m++) begin
                if (grant[s][m]) begin
                    m_granted[m] = 1'b1;
                    sel_addr[s]  = addr_q[m] - S_BASE[s];
                    sel_we[s]    = we_q[m];
                    sel_size[s]  = size_q[m];
                    sel_wdata[s] = wdata_q[m];
                end
            end
        end
    end

    // Master next-state logic. A request in the RESP cycle is accepted
    // directly because m_busy is already low there.
    always_comb begin
        for (int unsigned m = 0; m < M_NUM; m++) begin
            st_d[m] = st_q[m];
            case (st_q[m])
                M_IDLE, M_RESP: begin
                    if (acc[m]) begin
                        st_d[m] = dec_hit[m] ? M_ARB : M_DECERR;
                    end else begin
                        st_d[m] = M_IDLE;
                    end
                end
                M_DECERR: st_d[m] = M_RESP;
                M_ARB: begin
                    if (m_granted[m]) begin
                        st_d[m] = M_SLV;
                    end
                end
                M_SLV: begin
                    if (s_done[tgt_q[m]] || s_tmo[tgt_q[m]]) begin
                        st_d[m] = M_RESP;
                    end
                end
                default: st_d[m] = M_IDLE;
            endcase
        end
    end

    // Master state register.
    always_ff @(posedge clk) begin
        for (int unsigned m = 0; m < M_NUM; m++) begin
            if (!rst) begin
                st_q[m] <= M_IDLE;
            end else begin
                st_q[m] <= st_d[m];
            end
        end
    end

    // Master command latch and response capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            tgt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            for (int unsigned m = 0; m < M_NUM; m++) begin
                if (acc[m]) begin
                    addr_q[m]  <= bus.m_addr[m];
                    we_q[m]    <= bus.m_we[m];
                    size_q[m]  <= bus.m_size[m];
                    wdata_q[m] <= bus.m_wdata[m];
                    tgt_q[m]   <= dec_idx[m];
                end
                if (st_q[m] == M_DECERR) begin
                    err_q[m]   <= 1'b1;
                    rdata_q[m] <= '0;
                end else if ((st_q[m] == M_SLV) && s_done[tgt_q[m]]) begin
                    err_q[m]   <= 1'b0;
                    rdata_q[m] <= bus.s_rdata[tgt_q[m]];
                end else if ((st_q[m] == M_SLV) && s_tmo[tgt_q[m]]) begin
                    err_q[m]   <= 1'b1;
                    rdata_q[m] <= '0;
                end
            end
        end
    end

    // Slave command issue, busy tracking and timeout counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_busy_q  <= '0;
            s_req_q   <= '0;
            s_we_q    <= '0;
            s_addr_q  <= '0;
            s_size_q  <= '0;
            s_wdata_q <= '0;
            for (int unsigned s = 0; s < S_NUM; s++) begin
                cnt_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < S_NUM; s++) begin
                s_req_q[s] <= s_gnt_any[s];
                if (s_gnt_any[s]) begin
                    s_busy_q[s]  <= 1'b1;
                    cnt_q[s]     <= '0;
                    s_we_q[s]    <= sel_we[s];
                    s_addr_q[s]  <= sel_addr[s];
                    s_size_q[s]  <= sel_size[s];
                    s_wdata_q[s] <= sel_wdata[s];
                end else if (s_busy_q[s]) begin
                    if (s_done[s] || s_tmo[s]) begin
                        s_busy_q[s] <= 1'b0;
                        cnt_q[s]    <= '0;
                    end else begin
                        cnt_q[s] <= cnt_q[s] + 1'b1;
                    end
                end
            end
        end
    end

    // Master-side handshake outputs.
    always_comb begin
        bus.m_busy = '0;
        bus.m_ack  = '0;
        bus.m_err  = '0;
        for (int unsigned m = 0; m < M_NUM; m++) begin
            bus.m_busy[m] = (st_q[m] == M_DECERR) || (st_q[m] == M_ARB) || (st_q[m] == M_SLV);
            bus.m_ack[m]  = (st_q[m] == M_RESP);
            bus.m_err[m]  = (st_q[m] == M_RESP) && err_q[m];
        end
    end

    assign bus.m_rdata = rdata_q;
    assign bus.s_req   = s_req_q;
    assign bus.s_we    = s_we_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_size  = s_size_q;
    assign bus.s_wdata = s_wdata_q;

endmodule

// File: tb/tb_bus_matrix.sv
// Scoreboard bench for bus_matrix: responses are predicted at issue time
// and matched against every m_ack pulse.
module tb_bus_matrix;
    import bus_matrix_pkg::*;

    localparam int M = 3;
    localparam int S = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_matrix_if #(.M_NUM(M), .S_NUM(S)) bus ();

    bus_matrix #(
        .M_NUM   (M),
        .S_NUM   (S),
        .TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb [M][$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ack_dly [S];
    bit   ack_en  [S];
    bit   inject  [S];
    int   pend    [S];

    always @(posedge clk) cyc++;

    function automatic logic [31:0] slave_data(input int s, input logic [31:0] off);
        return 32'hDEADBEEF ^ off ^ (32'(s) << 24);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and predict its response.
    task automatic issue(input int m, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input bit tmo);
        exp_t e;
        bus.m_req[m]   = 1'b1;
        bus.m_we[m]    = we;
        bus.m_addr[m]  = a;
        bus.m_size[m]  = 2'd2;
        bus.m_wdata[m] = wd;
        if (tmo) begin
            e.err = 1'b1; e.rdata = 32'h0;
        end else if (a >= 32'h8000_0000 && a < 32'h8001_0000) begin
            e.err = 1'b0; e.rdata = slave_data(0, a - 32'h8000_0000);
        end else if (a >= 32'h0200_0000 && a < 32'h0201_0000) begin
            e.err = 1'b0; e.rdata = slave_data(1, a - 32'h0200_0000);
        end else begin
            e.err = 1'b1; e.rdata = 32'h0;
        end
        sb[m].push_back(e);
    endtask

    task automatic release_req();
        bus.m_req = '0;
    endtask

    // Slave models: ack a fixed number of cycles after s_req.
    task automatic responder();
        forever begin
            @(negedge clk);
            for (int s = 0; s < S; s++) begin
                bus.s_ack[s] = 1'b0;
                if (pend[s] > 0) begin
                    pend[s]--;
                    if (pend[s] == 0) begin
                        bus.s_ack[s]   = 1'b1;
                        bus.s_rdata[s] = slave_data(s, bus.s_addr[s]);
                    end
                end
                if (inject[s]) begin
                    bus.s_ack[s]   = 1'b1;
                    bus.s_rdata[s] = 32'h0BAD0BAD;
                    inject[s]      = 1'b0;
                end
                if (bus.s_req[s] && ack_en[s]) pend[s] = ack_dly[s];
            end
        end
    endtask

    // Match every m_ack against the scoreboard.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < M; m++) begin
                if (bus.m_ack[m] === 1'b1) begin
                    checks++;
                    if (sb[m].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack m%0d: got ack at cycle %0d, required none", m, cyc);
                    end else begin
                        e = sb[m].pop_front();
                        if (bus.m_err[m] !== e.err || bus.m_rdata[m] !== e.rdata) begin
                            errors++;
                            $display("FAIL sb_resp m%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                                     m, bus.m_err[m], bus.m_rdata[m], e.err, e.rdata);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.m_busy !== '0 || bus.m_ack !== '0 || bus.m_err !== '0 || bus.m_rdata !== '0) begin
            errors++;
            $display("FAIL %s_m: got busy=%b ack=%b err=%b rdata=%h, required all 0",
                     name, bus.m_busy, bus.m_ack, bus.m_err, bus.m_rdata);
        end
        checks++;
        if (bus.s_req !== '0 || bus.s_we !== '0 || bus.s_addr !== '0 ||
            bus.s_size !== '0 || bus.s_wdata !== '0) begin
            errors++;
            $display("FAIL %s_s: got req=%b we=%b addr=%h size=%h wdata=%h, required all 0",
                     name, bus.s_req, bus.s_we, bus.s_addr, bus.s_size, bus.s_wdata);
        end
    endtask

    task automatic wait_ack(input int m, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.m_ack[m] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no m_ack[%0d] within %0d cycles, required one", name, m, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        ack_en[0] = 1'b1; ack_dly[0] = 1;
        tick();
        issue(0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        tick(); release_req();
        checks++;
        if (bus.m_busy[0] !== 1'b1) begin
            errors++; $display("FAIL hit_busy: got %b, required 1", bus.m_busy[0]);
        end
        tick();
        checks++;
        if (bus.s_req[0] !== 1'b1 || bus.s_addr[0] !== 32'h0 || bus.s_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_sreq: got req=%b addr=%h we=%b, required req=1 addr=0 we=0",
                     bus.s_req[0], bus.s_addr[0], bus.s_we[0]);
        end
        tick();
        checks++;
        if (bus.m_ack[0] !== 1'b0) begin
            errors++; $display("FAIL hit_early_ack: got %b at cycle 3, required 0", bus.m_ack[0]);
        end
        tick();
        checks++;
        if (bus.m_ack[0] !== 1'b1 || bus.m_err[0] !== 1'b0 ||
            bus.m_rdata[0] !== 32'hDEADBEEF || bus.m_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_ack: got ack=%b err=%b rdata=%h busy=%b, required 1 0 deadbeef 0",
                     bus.m_ack[0], bus.m_err[0], bus.m_rdata[0], bus.m_busy[0]);
        end
        tick();
        checks++;
        if (bus.m_ack[0] !== 1'b0 || bus.m_rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hit_hold: got ack=%b rdata=%h, required ack=0 rdata=deadbeef",
                     bus.m_ack[0], bus.m_rdata[0]);
        end
    endtask

    task automatic test_decode_error();
        bit sreq_seen = 1'b0;
        tick();
        issue(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        tick(); release_req();
        sreq_seen |= |bus.s_req;
        checks++;
        if (bus.m_busy[1] !== 1'b1) begin
            errors++; $display("FAIL decerr_busy: got %b, required 1", bus.m_busy[1]);
        end
        tick();
        sreq_seen |= |bus.s_req;
        checks++;
        if (bus.m_ack[1] !== 1'b1 || bus.m_err[1] !== 1'b1 || bus.m_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL decerr_ack: got ack=%b err=%b rdata=%h, required 1 1 0",
                     bus.m_ack[1], bus.m_err[1], bus.m_rdata[1]);
        end
        tick();
        sreq_seen |= |bus.s_req;
        checks++;
        if (sreq_seen) begin
            errors++; $display("FAIL decerr_no_sreq: got s_req pulse, required none");
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        rst = 1'b0; tick(); rst = 1'b1; tick();
        ack_en[0] = 1'b1; ack_dly[0] = 1;
        for (int r = 0; r < 2; r++) begin
            order.delete();
            issue(0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
            issue(1, 1'b0, 32'h8000_0004, 32'h0, 1'b0);
            issue(2, 1'b1, 32'h8000_0008, 32'hCAFE_0002, 1'b0);
            tick(); release_req();
            for (int i = 0; i < 30; i++) begin
                if (bus.s_req[0] === 1'b1) begin
                    order.push_back(int'(bus.s_addr[0] >> 2));
                    if (bus.s_addr[0] == 32'h8) begin
                        checks++;
                        if (bus.s_we[0] !== 1'b1 || bus.s_wdata[0] !== 32'hCAFE_0002) begin
                            errors++;
                            $display("FAIL rr_write: got we=%b wdata=%h, required 1 cafe0002",
                                     bus.s_we[0], bus.s_wdata[0]);
                        end
                    end
                end
                tick();
            end
            checks++;
            if (order.size() != 3) begin
                errors++;
                $display("FAIL rr_count r%0d: got %0d grants, required 3", r, order.size());
            end else begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (order[k] != k) begin
                        errors++;
                        $display("FAIL rr_order r%0d[%0d]: got master %0d, required %0d", r, k, order[k], k);
                    end
                end
            end
            for (int m = 0; m < M; m++) begin
                checks++;
                if (sb[m].size() != 0) begin
                    errors++;
                    $display("FAIL rr_acks r%0d m%0d: got %0d pending, required 0", r, m, sb[m].size());
                end
            end
        end
    endtask

    task automatic test_timeout();
        int  t_sreq = 0;
        int  t_ack = 0;
        bit  seen = 1'b0;
        bit  stray = 1'b0;
        ack_en[1] = 1'b0;
        tick();
        issue(0, 1'b0, 32'h0200_0000, 32'h0, 1'b1);
        tick(); release_req();
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.s_req[1] === 1'b1) begin seen = 1'b1; t_sreq = cyc; end
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL tmo_sreq: got no s_req[1], required one");
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (bus.m_ack[0] === 1'b1) begin seen = 1'b1; t_ack = cyc; end
        end
        checks++;
        if (!seen || (t_ack - t_sreq) != 64) begin
            errors++;
            $display("FAIL tmo_latency: got seen=%b delta=%0d, required delta=64", seen, t_ack - t_sreq);
        end
        tick(); tick();
        inject[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            stray |= (bus.m_ack !== '0) || (bus.m_busy !== '0);
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL tmo_stale: got activity after stale s_ack, required none");
        end
        ack_en[1] = 1'b1; ack_dly[1] = 2;
        issue(0, 1'b0, 32'h0200_0004, 32'h0, 1'b0);
        tick(); release_req();
        wait_ack(0, 20, "tmo_recover");
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit stray = 1'b0;
        ack_en[0] = 1'b1; ack_dly[0] = 10;
        tick();
        issue(2, 1'b1, 32'h8000_0040, 32'h1234_5678, 1'b0);
        tick(); release_req();
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.s_req[0] === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || bus.s_addr[0] !== 32'h40 || bus.s_we[0] !== 1'b1 || bus.s_wdata[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rstmid_sreq: got seen=%b addr=%h we=%b wdata=%h, required 1 40 1 12345678",
                     seen, bus.s_addr[0], bus.s_we[0], bus.s_wdata[0]);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        check_all_zero("rstmid");
        rst = 1'b1;
        sb[2].delete();
        for (int i = 0; i < 15; i++) begin
            tick();
            stray |= (bus.m_ack !== '0);
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL rstmid_noack: got m_ack after reset, required none");
        end
        ack_dly[0] = 1;
        issue(2, 1'b1, 32'h8000_0044, 32'h0BEE_F00D, 1'b0);
        tick(); release_req();
        wait_ack(2, 20, "rstmid_recover");
    endtask

    task automatic test_ignore_rereq();
        int n_sreq = 0;
        logic [31:0] first_addr = 32'hFFFF_FFFF;
        ack_en[0] = 1'b1; ack_dly[0] = 3;
        tick();
        issue(1, 1'b0, 32'h8000_0020, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i < 4) begin
                bus.m_req[1]  = 1'b1;
                bus.m_addr[1] = 32'h8000_0080;
            end else begin
                release_req();
            end
            if (bus.s_req[0] === 1'b1) begin
                n_sreq++;
                if (n_sreq == 1) first_addr = bus.s_addr[0];
            end
        end
        checks++;
        if (n_sreq != 1 || first_addr !== 32'h20) begin
            errors++;
            $display("FAIL rereq: got %0d s_req addr=%h, required 1 s_req addr=00000020", n_sreq, first_addr);
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.m_req   = '0;
        bus.m_we    = '0;
        bus.m_addr  = '0;
        bus.m_size  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        for (int s = 0; s < S; s++) begin
            ack_dly[s] = 1; ack_en[s] = 1'b1; inject[s] = 1'b0; pend[s] = 0;
        end
        fork
            responder();
            monitor();
        join_none

        test_reset();
        test_read_hit();
        test_decode_error();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_ignore_rereq();
        tick(); tick();

        for (int m = 0; m < M; m++) begin
            checks++;
            if (sb[m].size() != 0) begin
                errors++;
                $display("FAIL sb_drain m%0d: got %0d outstanding, required 0", m, sb[m].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
